// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with req/ack memory handshakes.
// Optional performance counters (cycle_cnt, instret) enabled by defining RISCV_CTRL_PERF_EN.
module riscv_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TMO_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic [2:0] fn3,
  input  logic       fn7_b5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       instr_done,
  output logic       halted,
  output logic [1:0] err
`ifdef RISCV_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_ECALL   = 2'b11;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             taken;

  // funct7 bit is consumed by the ALU decoder, not by sequencing
  logic unused_fn7;
  assign unused_fn7 = fn7_b5;

  always_comb begin
    case (fn3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    err_d      = err_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    wb_sel     = 2'b00;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      // Counter is zero on entry; an ack in the final allowed cycle still wins
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = ERR_BUS;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_ECALL: begin
            state_d = S_HALT;
            err_d   = ERR_ECALL;
          end
          OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BR, OP_JAL: state_d = S_EXEC;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          OP_I: begin
            alu_op    = 2'b10;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LUI: begin
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_BR: begin
            alu_op     = 2'b01;
            pc_we      = 1'b1;
            pc_src     = taken;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL: state_d = S_WB;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = ERR_BUS;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
        if (opcode == OP_LOAD) begin
          wb_sel = 2'b01;
        end else if (opcode == OP_JAL) begin
          wb_sel = 2'b10;
          pc_src = 1'b1;
        end
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  assign err = err_q;

`ifdef RISCV_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: directed vector table, corner sequences and
// randomized instructions checked against a per-instruction phase model.
module tb_riscv_multicycle_ctrl;

  localparam int TMO = 16;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  // Output vector bit positions
  localparam logic [15:0] IMREQ  = 16'h8000;
  localparam logic [15:0] IRWE   = 16'h4000;
  localparam logic [15:0] PCWE   = 16'h2000;
  localparam logic [15:0] PCSRC  = 16'h1000;
  localparam logic [15:0] ASB    = 16'h0800;
  localparam logic [15:0] AOPFN  = 16'h0400;
  localparam logic [15:0] AOPSUB = 16'h0200;
  localparam logic [15:0] REGWE  = 16'h0100;
  localparam logic [15:0] WBPC   = 16'h0080;
  localparam logic [15:0] WBMEM  = 16'h0040;
  localparam logic [15:0] DREQ   = 16'h0020;
  localparam logic [15:0] DWE    = 16'h0010;
  localparam logic [15:0] DONE   = 16'h0008;
  localparam logic [15:0] HALTD  = 16'h0004;

  logic       clk, reset, start, fn7_b5, alu_zero, alu_lt, imem_ack, dmem_ack;
  logic [6:0] opcode;
  logic [2:0] fn3;
  logic       imem_req, ir_we, pc_we, pc_src, alu_src_b, reg_we, dmem_req, dmem_we;
  logic       instr_done, halted;
  logic [1:0] alu_op, wb_sel, err;
`ifdef RISCV_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret;
`endif

  int checks = 0;
  int errors = 0;

  riscv_multicycle_ctrl #(.TIMEOUT(TMO), .TMO_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .fn3(fn3), .fn7_b5(fn7_b5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .instr_done(instr_done), .halted(halted), .err(err)
`ifdef RISCV_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        lt;
    logic        ia;
    logic        da;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[19];
  logic [6:0] legal_ops[7];

  function automatic vec_t mk(input logic rst, input logic st, input logic [6:0] op,
                              input logic [2:0] f3, input logic z, input logic lt,
                              input logic chk, input logic [15:0] exp);
    vec_t v;
    v.rst = rst; v.st = st; v.op = op; v.f3 = f3; v.z = z; v.lt = lt;
    v.ia = 1'b1; v.da = 1'b1; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive acks, compare outputs at the falling edge, advance past the rising edge
  task automatic tick(input logic ia, input logic da, input logic [15:0] exp, input string name);
    logic [15:0] got;
    imem_ack = ia;
    dmem_ack = da;
    @(negedge clk);
    got = {imem_req, ir_we, pc_we, pc_src, alu_src_b, alu_op, reg_we, wb_sel,
           dmem_req, dmem_we, instr_done, halted, err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_nc();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b0; start = 1'b0;
    tick_nc();
    tick(rb(), rb(), '0, "reset_idle");
    reset = 1'b1; start = 1'b1;
    tick(rb(), rb(), '0, "idle_start");
    start = 1'b0;
  endtask

  task automatic halt_cycles(input logic [1:0] e, input string name);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, HALTD | {14'd0, e}, name);
  endtask

  // Phase-level model: fetch waits, decode, execute by class, memory waits, writeback
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input logic l, input int iw, input int dw, output bit hlt);
    logic [15:0] ex;
    hlt = 1'b1;
    opcode = op; fn3 = f3; alu_zero = z; alu_lt = l; fn7_b5 = rb();
    reset = 1'b1; start = rb();
    for (int k = 0; k < iw && k < TMO; k++) tick(1'b0, rb(), IMREQ, "fetch_wait");
    if (iw >= TMO) begin halt_cycles(2'b10, "fetch_timeout"); return; end
    tick(1'b1, rb(), IMREQ | IRWE, "fetch_ack");
    tick(rb(), rb(), '0, "decode");
    if (op == OP_ECALL) begin halt_cycles(2'b11, "ecall_halt"); return; end
    if (!is_legal(op)) begin halt_cycles(2'b01, "illegal_halt"); return; end
    if (op == OP_BR) begin
      tick(rb(), rb(), AOPSUB | PCWE | DONE | (br_taken(f3, z, l) ? PCSRC : '0), "exec_branch");
      hlt = 1'b0;
      return;
    end
    ex = (op == OP_R) ? AOPFN : (op == OP_I) ? (AOPFN | ASB) : (op == OP_JAL) ? 16'h0 : ASB;
    tick(rb(), rb(), ex, "exec");
    if (op == OP_LOAD || op == OP_STORE) begin
      ex = DREQ | ((op == OP_STORE) ? DWE : 16'h0);
      for (int k = 0; k < dw && k < TMO; k++) tick(rb(), 1'b0, ex, "mem_wait");
      if (dw >= TMO) begin halt_cycles(2'b10, "mem_timeout"); return; end
      if (op == OP_STORE) begin
        tick(rb(), 1'b1, ex | PCWE | DONE, "mem_store_ack");
        hlt = 1'b0;
        return;
      end
      tick(rb(), 1'b1, ex, "mem_load_ack");
    end
    ex = REGWE | PCWE | DONE;
    if (op == OP_LOAD) ex |= WBMEM;
    if (op == OP_JAL) ex |= WBPC | PCSRC;
    tick(rb(), rb(), ex, "wb");
    hlt = 1'b0;
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 11);
    if (r < 7) return $urandom_range(0, 3);
    if (r < 10) return TMO - 1;
    if (r < 11) return TMO;
    return 0;
  endfunction

  initial begin
    bit         h;
    logic [6:0] op;
    int         sel;

    legal_ops[0] = OP_R;    legal_ops[1] = OP_I;     legal_ops[2] = OP_LUI;
    legal_ops[3] = OP_LOAD; legal_ops[4] = OP_STORE; legal_ops[5] = OP_BR;
    legal_ops[6] = OP_JAL;

    tbl[0]  = mk(0, 0, OP_R,  3'b000, 0, 0, 0, '0);
    tbl[1]  = mk(0, 0, OP_R,  3'b000, 0, 0, 1, '0);
    tbl[2]  = mk(1, 1, OP_R,  3'b000, 0, 0, 1, '0);
    tbl[3]  = mk(1, 0, OP_R,  3'b000, 0, 0, 1, IMREQ | IRWE);
    tbl[4]  = mk(1, 0, OP_R,  3'b000, 0, 0, 1, '0);
    tbl[5]  = mk(1, 0, OP_R,  3'b000, 0, 0, 1, AOPFN);
    tbl[6]  = mk(1, 0, OP_R,  3'b000, 0, 0, 1, REGWE | PCWE | DONE);
    tbl[7]  = mk(1, 0, OP_BR, 3'b000, 1, 0, 1, IMREQ | IRWE);
    tbl[8]  = mk(1, 0, OP_BR, 3'b000, 1, 0, 1, '0);
    tbl[9]  = mk(1, 0, OP_BR, 3'b000, 1, 0, 1, AOPSUB | PCWE | PCSRC | DONE);
    tbl[10] = mk(1, 0, OP_BR, 3'b000, 0, 0, 1, IMREQ | IRWE);
    tbl[11] = mk(1, 0, OP_BR, 3'b000, 0, 0, 1, '0);
    tbl[12] = mk(1, 0, OP_BR, 3'b000, 0, 0, 1, AOPSUB | PCWE | DONE);
    tbl[13] = mk(1, 0, OP_BR, 3'b001, 0, 0, 1, IMREQ | IRWE);
    tbl[14] = mk(1, 0, OP_BR, 3'b001, 0, 0, 1, '0);
    tbl[15] = mk(1, 0, OP_BR, 3'b001, 0, 0, 1, AOPSUB | PCWE | PCSRC | DONE);
    tbl[16] = mk(1, 0, OP_BR, 3'b110, 1, 1, 1, IMREQ | IRWE);
    tbl[17] = mk(1, 0, OP_BR, 3'b110, 1, 1, 1, '0);
    tbl[18] = mk(1, 0, OP_BR, 3'b110, 1, 1, 1, AOPSUB | PCWE | DONE);

    reset = 1'b0; start = 1'b0; opcode = OP_R; fn3 = '0; fn7_b5 = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

    foreach (tbl[i]) begin
      reset = tbl[i].rst; start = tbl[i].st; opcode = tbl[i].op; fn3 = tbl[i].f3;
      alu_zero = tbl[i].z; alu_lt = tbl[i].lt;
      if (tbl[i].chk) tick(tbl[i].ia, tbl[i].da, tbl[i].exp, $sformatf("vec%0d", i));
      else begin imem_ack = tbl[i].ia; dmem_ack = tbl[i].da; tick_nc(); end
    end

    // Corner sequences, starting from FETCH
    run_instr(OP_LOAD,  3'b010, 0, 0, 0, 3, h);
    run_instr(OP_STORE, 3'b010, 0, 0, 2, 0, h);
    run_instr(OP_JAL,   3'b000, 0, 0, 1, 0, h);
    run_instr(OP_LUI,   3'b000, 0, 0, 0, 0, h);
    run_instr(OP_I,     3'b000, 0, 0, TMO - 1, 0, h);
    run_instr(OP_LOAD,  3'b010, 0, 0, 0, TMO - 1, h);
    run_instr(OP_BR,    3'b100, 0, 1, 0, 0, h);
    run_instr(OP_BR,    3'b101, 0, 1, 0, 0, h);
    run_instr(OP_R,     3'b000, 0, 0, TMO, 0, h);
    restart();
    run_instr(OP_STORE, 3'b010, 0, 0, 0, TMO, h);
    restart();
    run_instr(OP_ECALL, 3'b000, 0, 0, 0, 0, h);
    restart();
    run_instr(7'b0000000, 3'b000, 0, 0, 0, 0, h);
    restart();

    // Reset asserted while a load is in MEM
    opcode = OP_LOAD;
    tick(1'b1, 1'b0, IMREQ | IRWE, "rm_fetch");
    tick(1'b0, 1'b1, '0, "rm_decode");
    tick(1'b0, 1'b0, ASB, "rm_exec");
    tick(1'b0, 1'b0, DREQ, "rm_mem");
    reset = 1'b0;
    tick(1'b0, 1'b0, DREQ, "rm_mem_rst");
    reset = 1'b1;
    tick(1'b1, 1'b1, '0, "rm_idle");
    tick(1'b1, 1'b1, '0, "rm_idle2");

    restart();
    for (int k = 0; k < 3; k++) run_instr(OP_R, 3'b000, 0, 0, 0, 0, h);
`ifdef RISCV_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== 32'd12) begin
      errors++;
      $display("FAIL cycle_cnt: got %0d expected 12", cycle_cnt);
    end
    checks++;
    if (instret !== 32'd3) begin
      errors++;
      $display("FAIL instret: got %0d expected 3", instret);
    end
`endif

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) op = legal_ops[sel];
      else if (sel == 7) op = OP_ECALL;
      else begin
        op = 7'($urandom);
        while (is_legal(op) || op == OP_ECALL) op = 7'($urandom);
      end
      run_instr(op, 3'($urandom), rb(), rb(), rand_wait(), rand_wait(), h);
      if (h) restart();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RISC-V datapath (PC, instruction register, register file, ALU, data memory) through fetch, decode, execute, memory and writeback.
- Replaces single-cycle combinational control with per-state strobes.
- Handshakes with instruction and data memories via req/ack.
- Reports retirement, halt and error status to the top level and testbench.

Parameters:
TIMEOUT, 16, max cycles waited for imem_ack/dmem_ack before bus-error halt (>=1)
TMO_W, 5, width of wait counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (reset=0 resets on clk rising edge)
start  in  1  leave IDLE and begin fetching
opcode  in  7  instruction[6:0] from instruction register
fn3  in  3  instruction[14:12]
fn7_b5  in  1  instruction[30]
alu_zero  in  1  ALU result == 0
alu_lt  in  1  ALU signed less-than
imem_ack  in  1  instruction word valid
dmem_ack  in  1  data access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_src  out  1  0: PC+4, 1: branch/jump target
alu_src_b  out  1  0: rs2, 1: immediate
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
reg_we  out  1  register-file write enable
wb_sel  out  2  00 ALU, 01 memory, 10 PC+4
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
instr_done  out  1  one-cycle retire pulse
halted  out  1  FSM in HALT
err  out  2  00 none, 01 illegal opcode, 10 bus timeout, 11 ECALL

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State and wait counter are registered.
- Outputs are combinational from the state register, the IR fields and the ack inputs.
- Reset: while reset=0, state<=IDLE, counter<=0, err<=00. All outputs read 0 in IDLE. Reset mid-instruction aborts with no further strobes.
- IDLE: start=1 -> FETCH next cycle.
- FETCH: imem_req=1.
  - imem_ack=1 in the same cycle: ir_we=1, go to DECODE. Zero-wait ack is legal.
  - Acks outside FETCH/MEM are ignored.
- DECODE: no strobes. Next state by opcode:
  - 1110011 (ECALL): HALT, err=11.
  - Any opcode not listed in EXEC: HALT, err=01.
  - Otherwise: EXEC.
- EXEC:
  - 0110011 (R-type): alu_op=10, alu_src_b=0 -> WB.
  - 0010011 (I-ALU): alu_op=10, alu_src_b=1 -> WB.
  - 0110111 (LUI): alu_op=00, alu_src_b=1 -> WB.
  - 0000011 (load), 0100011 (store): alu_op=00, alu_src_b=1 -> MEM.
  - 1100011 (branch): alu_op=01, alu_src_b=0, pc_we=1, instr_done=1 -> FETCH.
    - pc_src=taken, where taken = fn3 000: alu_zero; 001: !alu_zero; 100: alu_lt; 101: !alu_lt; other fn3: 0.
  - 1101111 (JAL): -> WB.
- MEM: dmem_req=1, dmem_we=1 for store.
  - On dmem_ack, load -> WB.
  - On dmem_ack, store -> pc_we=1, pc_src=0, instr_done=1, then FETCH.
- WB: reg_we=1, pc_we=1, instr_done=1 -> FETCH.
  - wb_sel: 01 for load, 10 for JAL, else 00.
  - pc_src: 1 for JAL, else 0.
- Wait counter: cleared on entry to FETCH/MEM, incremented each cycle without ack. Counter reaching TIMEOUT with no ack -> HALT, err=10.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins; the access completes normally.
- HALT: halted=1, err held, all strobes 0. Exit only via reset.
- CPI: ALU/LUI/JAL = 4 cycles, branch = 3, store = 4, load = 5. Add memory waits to each.

Optional Feature:
Macro RISCV_CTRL_PERF_EN.
- Defined: adds output ports cycle_cnt[31:0] and instret[31:0].
  - cycle_cnt counts every cycle the state is not IDLE/HALT.
  - instret increments on each instr_done.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset=0 for 2 cycles, then reset=1, start=1, imem_ack tied 1, opcode=0110011 -> states FETCH, DECODE, EXEC, WB. reg_we=1, wb_sel=00 in cycle 4; instr_done pulses once.
2. Load, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, then WB with wb_sel=01. Total 8 cycles from FETCH entry.
3. Branch fn3=000, alu_zero=1 -> pc_we=1, pc_src=1 in EXEC. Repeat with alu_zero=0 -> pc_src=0, 3 cycles each.
4. imem_ack held 0 (TIMEOUT=16) -> HALT after 16 FETCH cycles, err=10, halted=1. Later acks are ignored.
5. opcode=1110011 -> HALT, err=11; opcode=0000000 -> HALT, err=01. reset=0 mid-MEM -> IDLE, dmem_req=0 next cycle.
6. With RISCV_CTRL_PERF_EN: 3 R-type instructions, zero-wait -> instret=3, cycle_cnt=12.
